rv_iopmp_reg_guard: RTL and testbench
=====================================

// Module: rv_iopmp_reg_guard
// PURPOSE
//  Register-interface slice between the IOPMP cfg AXI-to-reg abstractor (upstream) and the IOPMP register file (downstream).
//  Registers each reg-bus request and cuts the combinational path between the two sides.
//  Answers misaligned or out-of-range accesses with an error and does not forward them.
//  Watchdog aborts requests the register file never acks, so a wedged slave cannot hang the AXI cfg port.
// PARAMETERS
//  ADDR_WIDTH      14             reg-bus address width
//  DATA_WIDTH      32             reg-bus data width (strb = DATA_WIDTH/8)
//  ADDR_LIMIT      14'h3000       first illegal byte address; addr >= ADDR_LIMIT -> error
//  TIMEOUT_CYCLES  256            max FWD cycles without mst ready; >= 2
//  reg_req_t       logic          {addr, write, wdata, wstrb, valid}
//  reg_rsp_t       logic          {rdata, error, ready}
// PORTS
//  clk_i          in   1        clock; single clock domain
//  rst_i          in   1        reset, asynchronous, active-high
//  slv_req_i      in   reg_req  request from the cfg abstractor
//  slv_rsp_o      out  reg_rsp  response to the cfg abstractor
//  mst_req_o      out  reg_req  request to the IOPMP register file
//  mst_rsp_i      in   reg_rsp  response from the register file
//  timeout_o      out  1        sticky: a watchdog abort has occurred
//  timeout_clr_i  in   1        clears timeout_o (a new abort in the same cycle wins)
//  busy_o         out  1        state != IDLE
// BEHAVIOUR
//  Reg protocol: requester holds valid and payload stable until the cycle with ready=1; that cycle completes the transfer.
//   - mst_rsp_i.ready may be combinational.
//   - slv_rsp_o.ready is always registered (state == RESP).
//  Reset: all outputs 0, including mst valid, slv ready, rdata, error, timeout_o and busy_o; state = IDLE; count = 0.
//   - Reset mid-transfer drops the transfer and does not answer upstream.
//  FSM states IDLE, FWD, RESP. Transitions:
//   - IDLE, slv valid, addr[1:0] != 0 or addr >= ADDR_LIMIT: latch error=1, rdata=0, go to RESP. Nothing is forwarded.
//   - IDLE, slv valid, legal: latch addr/write/wdata/wstrb into req_q, clear count, go to FWD.
//   - FWD: mst_req_o = req_q with valid=1; count increments each cycle.
//   - FWD, mst ready: latch rdata (0 on writes) and error, go to RESP.
//   - FWD, count == TIMEOUT_CYCLES-1 without ready: latch error=1, rdata=TIMEOUT_RDATA, set timeout_o, go to RESP.
//     mst valid drops with no handshake; a late ack from the register file is ignored.
//   - FWD, ready in the same cycle as count reaching the limit: ready wins; no timeout.
//   - RESP: slv_rsp_o = {rdata_q, error_q, ready=1} for exactly one cycle, then IDLE.
//  Latency: legal request seen at cycle T, mst valid at T+1. If ack at T+k (k >= 1), slv ready at T+k+1.
//   - Illegal request seen at T: slv ready at T+1.
//  Back-to-back: a request is accepted in IDLE only, so at most 1 is outstanding.
//   - Minimum spacing is 3 cycles per legal access and 2 per illegal access.
//  slv_rsp_o rdata and error are 0 whenever ready = 0. mst_req_o payload is 0 whenever valid = 0.
//  Counter width: $clog2(TIMEOUT_CYCLES); it saturates, never wraps.
//  wstrb is forwarded unchanged; wstrb == 0 is a legal access.
// STRUCTURE
//  rv_iopmp_reg_pkg: guard_state_e {IDLE, FWD, RESP}; TIMEOUT_RDATA = 32'hDEAD_BEEF; addr legality function.
//  Sub-module rv_iopmp_wdog_cnt: clear/enable/limit counter with a hit pulse. Also reused by other IOPMP slave guards.
//  Main module: FSM, request/response holding registers, sticky flag.
// TESTING
//  1. Read addr 14'h0010; slave acks 3 cycles after mst valid with rdata 32'h1234_5678
//     -> slv ready 1 cycle later with rdata 32'h1234_5678, error 0.
//  2. Write addr 14'h0020, wdata 32'hA5A5_A5A5, wstrb 4'hF; slave acks combinationally
//     -> mst sees the exact payload; slv ready 2 cycles after the request; rdata 0.
//  3. Read addr 14'h0022 (misaligned), then 14'h3000 (out of range)
//     -> each gets error=1, rdata 0, one cycle after the request; mst valid never asserts.
//  4. Slave never acks, TIMEOUT_CYCLES=8 -> mst valid high 8 cycles then low;
//     slv response error=1, rdata 32'hDEAD_BEEF; timeout_o=1 until timeout_clr_i.
//  5. Ack in the same cycle as the timeout limit -> normal response, timeout_o stays 0.
//     Timeout in the same cycle as timeout_clr_i -> timeout_o=1.
//  6. Assert rst_i while in FWD -> all outputs 0 and busy_o=0 asynchronously.
//     After release, a new read completes normally.

Source files
------------

// File: rtl/rv_iopmp_reg_pkg.sv
// Shared types and helpers for the IOPMP register-bus guard slice.
// Bus widths are fixed here so the request/response structs can live in the package.
package rv_iopmp_reg_pkg;

   localparam int unsigned REG_ADDR_WIDTH = 14;
   localparam int unsigned REG_DATA_WIDTH = 32;
   localparam int unsigned REG_STRB_WIDTH = REG_DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FWD  = 2'd1,
      RESP = 2'd2
   } guard_state_e;

   localparam logic [REG_DATA_WIDTH-1:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

   typedef struct packed {
      logic [REG_ADDR_WIDTH-1:0] addr;
      logic                      write;
      logic [REG_DATA_WIDTH-1:0] wdata;
      logic [REG_STRB_WIDTH-1:0] wstrb;
      logic                      valid;
   } reg_req_t;

   typedef struct packed {
      logic [REG_DATA_WIDTH-1:0] rdata;
      logic                      error;
      logic                      ready;
   } reg_rsp_t;

   // Word-aligned and below the first illegal byte address.
   function automatic logic addr_legal(input logic [REG_ADDR_WIDTH-1:0] addr,
                                       input logic [REG_ADDR_WIDTH-1:0] limit);
      return (addr[1:0] == 2'b00) && (addr < limit);
   endfunction

endpackage

// File: rtl/rv_iopmp_wdog_cnt.sv
// Watchdog counter: clears, counts while enabled, saturates at the limit.
// hit_o flags an enabled cycle in which the count already sits at the limit.
module rv_iopmp_wdog_cnt #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [WIDTH-1:0] limit_i,
   output logic             hit_o
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != limit_i)) begin
         cnt_d = cnt_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign hit_o = en_i && (cnt_q == limit_i);

endmodule

// File: rtl/rv_iopmp_reg_guard.sv
// Registered reg-bus slice in front of the IOPMP register file: filters illegal
// addresses locally and aborts transfers the register file never acknowledges.
module rv_iopmp_reg_guard
   import rv_iopmp_reg_pkg::*;
#(
   parameter int unsigned            ADDR_WIDTH     = REG_ADDR_WIDTH,
   parameter int unsigned            DATA_WIDTH     = REG_DATA_WIDTH,
   parameter logic [ADDR_WIDTH-1:0]  ADDR_LIMIT     = 14'h3000,
   parameter int unsigned            TIMEOUT_CYCLES = 256
) (
   input  logic     clk_i,
   input  logic     rst_i,
   input  reg_req_t slv_req_i,
   output reg_rsp_t slv_rsp_o,
   output reg_req_t mst_req_o,
   input  reg_rsp_t mst_rsp_i,
   output logic     timeout_o,
   input  logic     timeout_clr_i,
   output logic     busy_o
);

   localparam int unsigned          CNT_WIDTH = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

   guard_state_e              state_q;
   logic [ADDR_WIDTH-1:0]     addr_q;
   logic                      write_q;
   logic [DATA_WIDTH-1:0]     wdata_q;
   logic [DATA_WIDTH/8-1:0]   wstrb_q;
   logic [DATA_WIDTH-1:0]     rdata_q;
   logic                      error_q;
   logic                      timeout_q;
   logic                      wdog_hit;

   // Count restarts every idle cycle, so a fresh FWD phase always begins at zero.
   rv_iopmp_wdog_cnt #(
      .WIDTH (CNT_WIDTH)
   ) u_wdog (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clr_i   (state_q == IDLE),
      .en_i    (state_q == FWD),
      .limit_i (CNT_LIMIT),
      .hit_o   (wdog_hit)
   );

   // A late ack after an abort lands in IDLE, where mst_rsp_i is never looked at.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         write_q   <= 1'b0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         rdata_q   <= '0;
         error_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         if (timeout_clr_i) begin
            timeout_q <= 1'b0;
         end
         case (state_q)
            IDLE: begin
               if (slv_req_i.valid) begin
                  if (addr_legal(slv_req_i.addr, ADDR_LIMIT)) begin
                     addr_q  <= slv_req_i.addr;
                     write_q <= slv_req_i.write;
                     wdata_q <= slv_req_i.wdata;
                     wstrb_q <= slv_req_i.wstrb;
                     state_q <= FWD;
                  end else begin
                     rdata_q <= '0;
                     error_q <= 1'b1;
                     state_q <= RESP;
                  end
               end
            end
            FWD: begin
               if (mst_rsp_i.ready) begin
                  rdata_q <= write_q ? '0 : mst_rsp_i.rdata;
                  error_q <= mst_rsp_i.error;
                  state_q <= RESP;
               end else if (wdog_hit) begin
                  rdata_q   <= TIMEOUT_RDATA;
                  error_q   <= 1'b1;
                  timeout_q <= 1'b1;
                  state_q   <= RESP;
               end
            end
            RESP: begin
               rdata_q <= '0;
               error_q <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Payload and response fields are forced to zero outside their valid/ready windows.
   always_comb begin
      mst_req_o = '0;
      slv_rsp_o = '0;
      if (state_q == FWD) begin
         mst_req_o.addr  = addr_q;
         mst_req_o.write = write_q;
         mst_req_o.wdata = wdata_q;
         mst_req_o.wstrb = wstrb_q;
         mst_req_o.valid = 1'b1;
      end
      if (state_q == RESP) begin
         slv_rsp_o.rdata = rdata_q;
         slv_rsp_o.error = error_q;
         slv_rsp_o.ready = 1'b1;
      end
   end

   assign timeout_o = timeout_q;
   assign busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_rv_iopmp_reg_guard.sv
// Directed bench for rv_iopmp_reg_guard with an 8-cycle watchdog; the bench
// plays both the cfg abstractor and the register file.
module tb_rv_iopmp_reg_guard;
   import rv_iopmp_reg_pkg::*;

   logic     clock = 1'b0;
   logic     reset;
   reg_req_t slvReq;
   reg_rsp_t slvRsp;
   reg_req_t mstReq;
   reg_rsp_t mstRsp;
   logic     timeoutOut;
   logic     timeoutClr;
   logic     busyOut;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   rv_iopmp_reg_guard #(
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk_i         (clock),
      .rst_i         (reset),
      .slv_req_i     (slvReq),
      .slv_rsp_o     (slvRsp),
      .mst_req_o     (mstReq),
      .mst_rsp_i     (mstRsp),
      .timeout_o     (timeoutOut),
      .timeout_clr_i (timeoutClr),
      .busy_o        (busyOut)
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic applyStimulus(input logic [13:0] addr, input logic wr,
                                input logic [31:0] wdata, input logic [3:0] strb);
      slvReq = '{addr: addr, write: wr, wdata: wdata, wstrb: strb, valid: 1'b1};
   endtask

   task automatic setAck(input logic [31:0] rdata, input logic err, input logic rdy);
      mstRsp = '{rdata: rdata, error: err, ready: rdy};
   endtask

   function automatic logic [63:0] rsp(input logic [31:0] rdata, input logic err);
      reg_rsp_t r;
      r = '{rdata: rdata, error: err, ready: 1'b1};
      return 64'(r);
   endfunction

   initial begin
      reg_req_t expReq;
      reset      = 1'b1;
      slvReq     = '0;
      mstRsp     = '0;
      timeoutClr = 1'b0;
      #12;
      checkOutput("reset slv_rsp", 64'(slvRsp), 64'h0);
      checkOutput("reset mst_req", 64'(mstReq), 64'h0);
      checkOutput("reset timeout", 64'(timeoutOut), 64'h0);
      checkOutput("reset busy", 64'(busyOut), 64'h0);
      @(negedge clock);
      reset = 1'b0;
      tick();

      // Read with ack three cycles after mst valid rises.
      applyStimulus(14'h0010, 1'b0, 32'h0, 4'h0);
      tick();
      checkOutput("t1 mst valid", 64'(mstReq.valid), 64'h1);
      checkOutput("t1 mst addr", 64'(mstReq.addr), 64'h0010);
      checkOutput("t1 mst write", 64'(mstReq.write), 64'h0);
      checkOutput("t1 busy", 64'(busyOut), 64'h1);
      tick();
      tick();
      checkOutput("t1 slv not ready yet", 64'(slvRsp), 64'h0);
      tick();
      setAck(32'h1234_5678, 1'b0, 1'b1);
      tick();
      checkOutput("t1 slv rsp", 64'(slvRsp), rsp(32'h1234_5678, 1'b0));
      checkOutput("t1 mst valid low", 64'(mstReq.valid), 64'h0);
      slvReq = '0;
      mstRsp = '0;
      tick();
      checkOutput("t1 idle", 64'(busyOut), 64'h0);

      // Write with combinational ack; slave returns junk rdata that must be dropped.
      setAck(32'hFFFF_FFFF, 1'b0, 1'b1);
      applyStimulus(14'h0020, 1'b1, 32'hA5A5_A5A5, 4'hF);
      tick();
      expReq = '{addr: 14'h0020, write: 1'b1, wdata: 32'hA5A5_A5A5, wstrb: 4'hF, valid: 1'b1};
      checkOutput("t2 mst payload", 64'(mstReq), 64'(expReq));
      checkOutput("t2 slv not ready", 64'(slvRsp), 64'h0);
      tick();
      checkOutput("t2 slv rsp", 64'(slvRsp), rsp(32'h0, 1'b0));
      slvReq = '0;
      mstRsp = '0;
      tick();

      // Misaligned, then first out-of-range address, then last legal word.
      applyStimulus(14'h0022, 1'b0, 32'h0, 4'h0);
      tick();
      checkOutput("t3 misaligned rsp", 64'(slvRsp), rsp(32'h0, 1'b1));
      checkOutput("t3 misaligned no fwd", 64'(mstReq), 64'h0);
      slvReq = '0;
      tick();
      checkOutput("t3 misaligned idle", 64'(busyOut), 64'h0);
      applyStimulus(14'h3000, 1'b0, 32'h0, 4'h0);
      tick();
      checkOutput("t3 range rsp", 64'(slvRsp), rsp(32'h0, 1'b1));
      checkOutput("t3 range no fwd", 64'(mstReq), 64'h0);
      slvReq = '0;
      tick();
      checkOutput("t3 range no fwd later", 64'(mstReq.valid), 64'h0);
      setAck(32'h0000_0077, 1'b0, 1'b1);
      applyStimulus(14'h2FFC, 1'b0, 32'h0, 4'h0);
      tick();
      checkOutput("t3 last word fwd", 64'(mstReq.addr), 64'h2FFC);
      tick();
      checkOutput("t3 last word rsp", 64'(slvRsp), rsp(32'h0000_0077, 1'b0));
      slvReq = '0;
      mstRsp = '0;
      tick();

      // Slave never acks: eight FWD cycles, then a watchdog abort.
      applyStimulus(14'h0040, 1'b0, 32'h0, 4'h0);
      for (int i = 1; i <= 8; i++) begin
         tick();
         checkOutput($sformatf("t4 mst valid cycle %0d", i), 64'(mstReq.valid), 64'h1);
      end
      tick();
      checkOutput("t4 mst valid dropped", 64'(mstReq.valid), 64'h0);
      checkOutput("t4 slv rsp", 64'(slvRsp), rsp(32'hDEAD_BEEF, 1'b1));
      checkOutput("t4 timeout set", 64'(timeoutOut), 64'h1);
      slvReq = '0;
      setAck(32'h0000_0001, 1'b0, 1'b1);
      tick();
      checkOutput("t4 late ack ignored", 64'(slvRsp), 64'h0);
      checkOutput("t4 late ack idle", 64'(busyOut), 64'h0);
      checkOutput("t4 timeout sticky", 64'(timeoutOut), 64'h1);
      mstRsp     = '0;
      timeoutClr = 1'b1;
      tick();
      checkOutput("t4 timeout cleared", 64'(timeoutOut), 64'h0);
      timeoutClr = 1'b0;

      // Ack in the limit cycle wins over the watchdog.
      applyStimulus(14'h0044, 1'b0, 32'h0, 4'h0);
      for (int i = 1; i <= 8; i++) begin
         tick();
      end
      setAck(32'hCAFE_F00D, 1'b0, 1'b1);
      tick();
      checkOutput("t5 ack at limit rsp", 64'(slvRsp), rsp(32'hCAFE_F00D, 1'b0));
      checkOutput("t5 ack at limit no timeout", 64'(timeoutOut), 64'h0);
      slvReq = '0;
      mstRsp = '0;
      tick();

      // Abort in the same cycle as a clear: the abort wins.
      applyStimulus(14'h0048, 1'b0, 32'h0, 4'h0);
      for (int i = 1; i <= 8; i++) begin
         tick();
      end
      timeoutClr = 1'b1;
      tick();
      checkOutput("t5 abort beats clear", 64'(timeoutOut), 64'h1);
      checkOutput("t5 abort rsp", 64'(slvRsp), rsp(32'hDEAD_BEEF, 1'b1));
      timeoutClr = 1'b0;
      slvReq     = '0;
      tick();

      // Asynchronous reset in the middle of a forward.
      applyStimulus(14'h004C, 1'b0, 32'h0, 4'h0);
      tick();
      checkOutput("t6 in fwd", 64'(busyOut), 64'h1);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("t6 reset mst_req", 64'(mstReq), 64'h0);
      checkOutput("t6 reset slv_rsp", 64'(slvRsp), 64'h0);
      checkOutput("t6 reset busy", 64'(busyOut), 64'h0);
      checkOutput("t6 reset timeout", 64'(timeoutOut), 64'h0);
      slvReq = '0;
      @(negedge clock);
      reset = 1'b0;
      tick();
      setAck(32'h0BAD_F00D, 1'b0, 1'b1);
      applyStimulus(14'h0050, 1'b0, 32'h0, 4'h0);
      tick();
      checkOutput("t6 post reset fwd", 64'(mstReq.addr), 64'h0050);
      tick();
      checkOutput("t6 post reset rsp", 64'(slvRsp), rsp(32'h0BAD_F00D, 1'b0));
      slvReq = '0;
      mstRsp = '0;
      tick();
      checkOutput("t6 final idle", 64'(busyOut), 64'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
